// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Holds the halt/drain state encoding, default pipeline latencies and the
// standard operand slack values a decoder hands to the scoreboard.
package hazard_pkg;

  // RUN: normal issue; DRAIN: HLT accepted, waiting for writers to retire;
  // HALTED: terminal until reset.
  typedef enum logic [1:0] {
    HS_RUN,
    HS_DRAIN,
    HS_HALTED
  } hs_state_t;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ALU_LAT  = 2;
  localparam int DEF_LOAD_LAT = 3;
  localparam int DEF_FLAG_LAT = 1;
  localparam int DEF_STAT_W   = 16;

  // How many pending cycles a consumer can tolerate on an operand:
  // read in ID, consumed as an EX operand, or store data forwarded MEM-to-MEM.
  localparam int SLACK_ID  = 0;
  localparam int SLACK_EX  = 2;
  localparam int SLACK_MEM = 3;

endpackage

// File: rtl/hs_pend_counter.sv
// Pending-cycle down-counter for one scoreboard entry.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   freeze_i     hold the count (memory stall)
//   load_i       load load_val_i (takes priority over the decrement)
//   load_val_i   latency to load
//   count_o      current pending count
//   zero_o       count_o == 0
module hs_pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Freeze wins over everything; a load overrides the normal decrement.
  always_comb begin
    count_d = count_q;
    if (!freeze_i) begin
      if (load_i) begin
        count_d = load_val_i;
      end else if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard.
// Tracks, per architectural register and for the Z/NV flags, how many cycles
// remain until the producing instruction's result can be forwarded. A consumer
// stalls while the pending count exceeds the slack it can tolerate. Also
// freezes on memory stalls, drains the pipeline on HLT and counts stall cycles.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   id_valid .. id_is_hlt       decoded instruction currently in ID
//   mem_stall                   data memory busy, freeze the pipeline
//   branch_mispredicted/_taken  branch resolution in ID
//   pc_stall, if_id_stall       hold PC and IF/ID
//   id_flush                    inject a bubble into ID/EX
//   if_flush                    squash the fetched instruction
//   halted                      halt drain complete
//   stall_count                 saturating count of hazard-stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int FLAG_LAT = DEF_FLAG_LAT,
  parameter int CNT_W    = $clog2(LOAD_LAT + 1),
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_src1,
  input  logic              id_src1_en,
  input  logic [CNT_W-1:0]  id_src1_slack,
  input  logic [REG_W-1:0]  id_src2,
  input  logic              id_src2_en,
  input  logic [CNT_W-1:0]  id_src2_slack,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              id_sets_flags,
  input  logic              id_uses_flags,
  input  logic              id_is_hlt,
  input  logic              mem_stall,
  input  logic              branch_mispredicted,
  input  logic              branch_taken,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_flush,
  output logic              if_flush,
  output logic              halted,
  output logic [STAT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] ALU_V  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] FLAG_V = CNT_W'(FLAG_LAT);

  hs_state_t state_q;
  hs_state_t state_d;
  logic [STAT_W-1:0] stall_count_q;
  logic [STAT_W-1:0] stall_count_d;

  logic [CNT_W-1:0]    pend [NUM_REGS];
  logic [NUM_REGS-1:0] pend_zero;
  logic [CNT_W-1:0]    flag_pend;
  logic                flag_zero;

  logic run;
  logic src1_haz;
  logic src2_haz;
  logic flag_haz;
  logic hazard;
  logic issue;
  logic wr_load;
  logic [CNT_W-1:0] wr_lat;
  logic all_clear;

  assign run = (state_q == HS_RUN);

  // Register 0 never reads as pending, so it is excluded by index as well.
  assign src1_haz = id_src1_en && (id_src1 != '0) && (pend[id_src1] > id_src1_slack);
  assign src2_haz = id_src2_en && (id_src2 != '0) && (pend[id_src2] > id_src2_slack);
  assign flag_haz = id_uses_flags && !flag_zero;
  assign hazard   = id_valid && (src1_haz || src2_haz || flag_haz);

  assign issue   = id_valid && !hazard && !mem_stall && run && !id_is_hlt;
  assign wr_load = issue && id_regwrite;
  assign wr_lat  = id_is_load ? LOAD_V : ALU_V;

  // Entry 0 is the hard-wired zero register and never carries a counter.
  assign pend[0]      = '0;
  assign pend_zero[0] = 1'b1;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    hs_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .freeze_i   (mem_stall),
      .load_i     (wr_load && (id_dst == REG_W'(r))),
      .load_val_i (wr_lat),
      .count_o    (pend[r]),
      .zero_o     (pend_zero[r])
    );
  end

  hs_pend_counter #(.CNT_W(CNT_W)) u_flag_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .freeze_i   (mem_stall),
    .load_i     (issue && id_sets_flags),
    .load_val_i (FLAG_V),
    .count_o    (flag_pend),
    .zero_o     (flag_zero)
  );

  assign all_clear = (&pend_zero) && flag_zero;

  // Halt FSM: an HLT only leaves RUN once it is itself hazard-free, and the
  // drain completes when every in-flight writer has retired.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HS_RUN:    if (id_valid && id_is_hlt && !hazard && !mem_stall) state_d = HS_DRAIN;
      HS_DRAIN:  if (all_clear && !mem_stall) state_d = HS_DRAIN == HS_DRAIN ? HS_HALTED : HS_DRAIN;
      HS_HALTED: state_d = HS_HALTED;
      default:   state_d = HS_RUN;
    endcase
  end

  // Only genuine hazard stalls in RUN are counted; memory-stall cycles are not.
  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard && !mem_stall && run && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HS_RUN;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pc_stall    = mem_stall || hazard || (id_valid && id_is_hlt) || !run;
  assign if_id_stall = pc_stall;
  assign id_flush    = !mem_stall && (!run || hazard || (id_valid && id_is_hlt));
  // An unresolved (stalled) branch must not squash the fetch stream yet.
  assign if_flush    = branch_mispredicted && branch_taken && !hazard && !mem_stall;
  assign halted      = (state_q == HS_HALTED);
  assign stall_count = stall_count_q;

endmodule
